seq_bit_serializer: RTL

Upstream feeder stage for the 1011 sequence detector.
- Accepts parallel WIDTH-bit words over a valid/ready handshake.
- Shifts each word out one bit per clock on inp_bit, which connects directly to the detector's inp_bit input.
- Holds one word in a buffer so back-to-back words form a gapless bit stream; this is required so overlapping patterns that span a word boundary are still detected.

---
 rtl/seq_bit_serializer_pkg.sv | 19 +
 rtl/seq_bit_serializer_if.sv | 36 +++
 rtl/seq_bit_serializer_word_buffer.sv | 53 +++++
 rtl/seq_bit_serializer.sv | 106 ++++++++++
 4 files changed

// File: rtl/seq_bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and defaults for the bit serializer that feeds the 1011
// sequence detector.
//   state_t          : serializer FSM state
//   WIDTH_DEFAULT    : default parallel word width
//   IDLE_BIT_DEFAULT : default inp_bit level while nothing is being shifted
// -----------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int   WIDTH_DEFAULT    = 8;
   localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer_if
// Bundles the word handshake and the serial stream of the serializer.
//   in_data/in_valid/in_ready : parallel word handshake (upstream -> block)
//   flush                     : synchronous discard of buffered/in-flight data
//   inp_bit/bit_valid         : serial bit and its qualifier (block -> detector)
//   word_start                : first bit of a word is on inp_bit
//   stream_gap                : one-cycle pulse after a last bit with no follow-on
// master = upstream producer, slave = the serializer.
// -----------------------------------------------------------------------------
interface seq_bit_serializer_if
   import seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) ();

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic             inp_bit;
   logic             bit_valid;
   logic             word_start;
   logic             stream_gap;

   modport master (
      output in_data, in_valid, flush,
      input  in_ready, inp_bit, bit_valid, word_start, stream_gap
   );

   modport slave (
      input  in_data, in_valid, flush,
      output in_ready, inp_bit, bit_valid, word_start, stream_gap
   );

endinterface

// File: rtl/seq_bit_serializer_word_buffer.sv
// -----------------------------------------------------------------------------
// seq_word_buffer
// Single-entry holding register between the word handshake and the shifter.
// It lets the next word wait while the current one is shifted, so that words
// follow each other with no idle bit in between.
//   clk, reset : clock, async active-low reset
//   flush      : empties the buffer and blocks acceptance this cycle
//   in_data    : incoming word
//   in_valid   : incoming word valid
//   drain      : shifter can take a word at the next edge (idle or last bit)
//   in_ready   : buffer can accept in_data this cycle
//   pop        : buffered word moves to the shifter at the next edge
//   hbuf       : buffered word
// -----------------------------------------------------------------------------
module seq_word_buffer
   import seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             drain,
   output logic             in_ready,
   output logic             pop,
   output logic [WIDTH-1:0] hbuf
);

   logic hvalid;
   logic accept;

   assign pop      = hvalid & drain;
   // A full buffer can still take a word on the cycle it hands its own word on.
   assign in_ready = ~flush & (~hvalid | pop);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hvalid <= 1'b0;
         hbuf   <= '0;
      end else if (flush) begin
         hvalid <= 1'b0;
      end else if (accept) begin
         hbuf   <= in_data;
         hvalid <= 1'b1;
      end else if (pop) begin
         hvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
// Turns parallel words into a gapless serial stream for the 1011 detector.
// A one-word buffer lets the next word load on the same edge as the last bit
// of the current word, so patterns spanning a word boundary stay intact.
//   clk   : clock, all state on posedge
//   reset : asynchronous active-low reset
//   bus   : seq_bit_serializer_if slave (handshake, flush, serial outputs)
//
//   state | meaning
//   IDLE  | no word in flight; inp_bit = IDLE_BIT, waits for a buffered word
//   SHIFT | word in flight; cnt = index of the bit currently on inp_bit
// -----------------------------------------------------------------------------
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int   WIDTH     = WIDTH_DEFAULT,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   seq_bit_serializer_if.slave bus
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_next;
   logic [WIDTH-1:0] hbuf;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             drain;
   logic             pop;
   logic             in_ready;
   logic             stream_gap;

   assign last_bit  = (state == SHIFT) && (cnt == LAST);
   assign drain     = (state == IDLE) || last_bit;
   assign sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

   seq_word_buffer #(
      .WIDTH (WIDTH)
   ) u_word_buffer (
      .clk      (clk),
      .reset    (reset),
      .flush    (bus.flush),
      .in_data  (bus.in_data),
      .in_valid (bus.in_valid),
      .drain    (drain),
      .in_ready (in_ready),
      .pop      (pop),
      .hbuf     (hbuf)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         sreg       <= '0;
         stream_gap <= 1'b0;
      end else if (bus.flush) begin
         state      <= IDLE;
         cnt        <= '0;
         stream_gap <= 1'b0;
      end else begin
         stream_gap <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  sreg  <= hbuf;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (pop) begin
                     sreg <= hbuf;
                  end else begin
                     state      <= IDLE;
                     stream_gap <= 1'b1;
                  end
               end else begin
                  sreg <= sreg_next;
                  cnt  <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.bit_valid  = (state == SHIFT);
   assign bus.word_start = (state == SHIFT) && (cnt == '0);
   assign bus.stream_gap = stream_gap;
   assign bus.inp_bit    = (state == SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;

endmodule
